// File: rtl/riscv_pkg.sv
// Shared types for the RVFI trace path: the stored retirement record and default sizing.
package riscv_pkg;

    localparam int TRACE_DEPTH_DEFAULT  = 16;
    localparam int TRACE_DROP_W_DEFAULT = 16;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] insn;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_wmask;
    } trace_rec_t;

endpackage

// File: rtl/rvfi_trace_buffer_if.sv
// Bundle between the retirement tracer, the trace buffer and its downstream consumer.
interface rvfi_trace_buffer_if #(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
);
    import riscv_pkg::*;

    logic                     rvfi_valid;
    logic [31:0]              rvfi_insn;
    logic [31:0]              rvfi_pc_rdata;
    logic [31:0]              rvfi_pc_wdata;
    logic [4:0]               rvfi_rd_addr;
    logic [31:0]              rvfi_rd_wdata;
    logic [31:0]              rvfi_mem_addr;
    logic [3:0]               rvfi_mem_wmask;
    logic                     trace_ready;
    logic                     trace_valid;
    trace_rec_t               trace_rec;
    logic [$clog2(DEPTH):0]   level;
    logic                     overflow;
    logic [DROP_W-1:0]        dropped;

    modport master (
        output rvfi_valid, rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rd_addr,
               rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_wmask, trace_ready,
        input  trace_valid, trace_rec, level, overflow, dropped
    );

    modport slave (
        input  rvfi_valid, rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rd_addr,
               rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_wmask, trace_ready,
        output trace_valid, trace_rec, level, overflow, dropped
    );

endinterface

// File: rtl/rvfi_trace_fifo_mem.sv
// Record storage for the trace FIFO: one synchronous write port, one combinational read port.
module rvfi_trace_fifo_mem
    import riscv_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH_DEFAULT,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  trace_rec_t    wdata,
    input  logic [AW-1:0] raddr,
    output trace_rec_t    rdata
);

    trace_rec_t mem_q [DEPTH];

    // NOTE: the array has no reset; entry validity is tracked by the level counter alone.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/rvfi_trace_buffer.sv
// Non-stalling retirement trace FIFO: stamps each RVFI record with an order number and
// drops (and counts) records that arrive while the buffer is full.
module rvfi_trace_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH  = TRACE_DEPTH_DEFAULT,
    parameter int DROP_W = TRACE_DROP_W_DEFAULT
) (
    input  logic                CLK,
    input  logic                Reset_n,
    rvfi_trace_buffer_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [63:0]       ord_q, ord_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] dropped_q, dropped_d;

    logic       full, empty, pop, do_push, drop;
    trace_rec_t rec_in;
    trace_rec_t rec_head;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign pop     = !empty && bus.trace_ready;
    // A pop frees the slot this cycle, so a full buffer still accepts a concurrent push.
    assign do_push = bus.rvfi_valid && (!full || pop);
    assign drop    = bus.rvfi_valid && full && !pop;

    always_comb begin
        rec_in           = '0;
        rec_in.order     = ord_q;
        rec_in.insn      = bus.rvfi_insn;
        rec_in.pc_rdata  = bus.rvfi_pc_rdata;
        rec_in.pc_wdata  = bus.rvfi_pc_wdata;
        rec_in.rd_addr   = bus.rvfi_rd_addr;
        rec_in.rd_wdata  = (bus.rvfi_rd_addr == 5'd0) ? 32'd0 : bus.rvfi_rd_wdata;
        rec_in.mem_addr  = bus.rvfi_mem_addr;
        rec_in.mem_wmask = bus.rvfi_mem_wmask;
    end

    always_comb begin
        // NOTE: each _d starts from its hold value so no path through this block infers a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ord_d      = ord_q;
        overflow_d = overflow_q;
        dropped_d  = dropped_q;

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!do_push && pop) begin
            level_d = level_q - LW'(1);
        end

        // Order advances on every retirement, stored or not, so drops show up as gaps.
        if (bus.rvfi_valid) begin
            ord_d = ord_q + 64'd1;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (dropped_q != '1) begin
                dropped_d = dropped_q + DROP_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ord_q      <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ord_q      <= ord_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
        end
    end

    rvfi_trace_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (CLK),
        .we    (do_push),
        .waddr (wr_ptr_q),
        .wdata (rec_in),
        .raddr (rd_ptr_q),
        .rdata (rec_head)
    );

    assign bus.trace_valid = !empty;
    assign bus.trace_rec   = rec_head;
    assign bus.level       = level_q;
    assign bus.overflow    = overflow_q;
    assign bus.dropped     = dropped_q;

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Self-checking bench for rvfi_trace_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_rvfi_trace_buffer;
    import riscv_pkg::*;

    localparam int DEPTH  = 16;
    localparam int DROP_W = 16;

    logic clk;
    logic rst_n;

    rvfi_trace_buffer_if #(.DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

    rvfi_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .CLK     (clk),
        .Reset_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    trace_rec_t  m_q [$];
    longint      m_ord;
    int          m_drop;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        int sat;
        sat = (m_drop > (2**DROP_W - 1)) ? (2**DROP_W - 1) : m_drop;
        check("valid", bus.trace_valid, m_q.size() != 0);
        check("level", bus.level, m_q.size());
        check("overflow", bus.overflow, m_drop != 0);
        check("dropped", bus.dropped, sat);
        if (m_q.size() != 0) check("head_rec", bus.trace_rec, m_q[0]);
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge.
    task automatic cycle(input logic v, input logic [31:0] insn, input logic [31:0] pc,
                         input logic [31:0] npc, input logic [4:0] rd, input logic [31:0] wd,
                         input logic [31:0] maddr, input logic [3:0] wm, input logic rdy);
        trace_rec_t r;
        bus.rvfi_valid     = v;
        bus.rvfi_insn      = insn;
        bus.rvfi_pc_rdata  = pc;
        bus.rvfi_pc_wdata  = npc;
        bus.rvfi_rd_addr   = rd;
        bus.rvfi_rd_wdata  = wd;
        bus.rvfi_mem_addr  = maddr;
        bus.rvfi_mem_wmask = wm;
        bus.trace_ready    = rdy;

        if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
        if (v) begin
            r.order     = m_ord;
            r.insn      = insn;
            r.pc_rdata  = pc;
            r.pc_wdata  = npc;
            r.rd_addr   = rd;
            r.rd_wdata  = (rd == 0) ? 32'd0 : wd;
            r.mem_addr  = maddr;
            r.mem_wmask = wm;
            if (m_q.size() < DEPTH) m_q.push_back(r);
            else m_drop++;
            m_ord++;
        end

        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic rand_cycle(input logic v, input logic rdy);
        cycle(v, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)), $urandom,
              $urandom, 4'($urandom), rdy);
    endtask

    // Reset is asserted between clock edges and checked before any edge arrives.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        bus.rvfi_valid  = 1'b0;
        bus.trace_ready = 1'b0;
        #1;
        check("rst_valid", bus.trace_valid, 1'b0);
        check("rst_level", bus.level, 0);
        check("rst_overflow", bus.overflow, 1'b0);
        check("rst_dropped", bus.dropped, 0);
        m_q.delete();
        m_ord  = 0;
        m_drop = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compare_model();
    endtask

    initial begin
        int p_push;
        int p_ready;

        rst_n = 1'b0;
        bus.rvfi_valid = 1'b0;
        bus.rvfi_insn = '0;
        bus.rvfi_pc_rdata = '0;
        bus.rvfi_pc_wdata = '0;
        bus.rvfi_rd_addr = '0;
        bus.rvfi_rd_wdata = '0;
        bus.rvfi_mem_addr = '0;
        bus.rvfi_mem_wmask = '0;
        bus.trace_ready = 1'b0;
        m_ord = 0;
        m_drop = 0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Single record after reset, then consume it.
        cycle(1'b1, 32'h00500093, 32'h0, 32'h4, 5'd1, 32'd5, 32'h0, 4'h0, 1'b0);
        check("single_valid", bus.trace_valid, 1'b1);
        check("single_order", bus.trace_rec.order, 0);
        check("single_level", bus.level, 1);
        check("single_wdata", bus.trace_rec.rd_wdata, 32'd5);
        cycle(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b1);
        check("single_pop_valid", bus.trace_valid, 1'b0);
        check("single_pop_level", bus.level, 0);

        // Fill past capacity with the consumer stalled.
        do_reset();
        for (int i = 0; i < 20; i++) rand_cycle(1'b1, 1'b0);
        check("fill_level", bus.level, 16);
        check("fill_overflow", bus.overflow, 1'b1);
        check("fill_dropped", bus.dropped, 4);
        for (int i = 0; i < 16; i++) begin
            check("drain_order", bus.trace_rec.order, i);
            cycle(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b1);
        end
        check("drained_level", bus.level, 0);

        // First push after the drops carries the gapped order number.
        rand_cycle(1'b1, 1'b0);
        check("gap_order", bus.trace_rec.order, 20);

        // x0 destination: write data must read back as zero.
        cycle(1'b1, 32'h00000013, 32'h100, 32'h104, 5'd0, 32'hDEADBEEF, 32'h0, 4'h0, 1'b1);
        check("x0_rd_addr", bus.trace_rec.rd_addr, 5'd0);
        check("x0_rd_wdata", bus.trace_rec.rd_wdata, 32'd0);
        check("x0_order", bus.trace_rec.order, 21);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 15; i++) rand_cycle(1'b1, 1'b0);
        check("full_level", bus.level, 16);
        rand_cycle(1'b1, 1'b1);
        check("pushpop_level", bus.level, 16);
        check("pushpop_dropped", bus.dropped, 4);
        for (int i = 0; i < 15; i++) cycle(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b1);
        check("pushpop_tail_order", bus.trace_rec.order, 37);
        check("pushpop_tail_level", bus.level, 1);

        // Asynchronous reset mid-stream with overflow set.
        for (int i = 0; i < 6; i++) rand_cycle(1'b1, 1'b0);
        check("pre_rst_level", bus.level, 7);
        check("pre_rst_overflow", bus.overflow, 1'b1);
        do_reset();
        rand_cycle(1'b1, 1'b0);
        check("post_rst_order", bus.trace_rec.order, 0);

        // Randomized traffic in phases of varying push and ready density.
        for (int ph = 0; ph < 12; ph++) begin
            p_push  = $urandom_range(30, 100);
            p_ready = $urandom_range(0, 100);
            for (int i = 0; i < 200; i++) begin
                rand_cycle($urandom_range(1, 100) <= p_push, $urandom_range(1, 100) <= p_ready);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
